// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer that shares one single-port Memory between instruction fetch
// (port 0) and load/store (port 1). Each access takes three cycles: IDLE -> ACCESS -> DONE.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 2010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(MEM_DEPTH);

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          ack_q, ack_d;
  logic [1:0]          err_q, err_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                grant;
  logic                in_range;

  // Unsigned compare of the full address, so huge addresses are rejected rather than wrapped.
  assign in_range = (addr_q < DEPTH_C);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    port_d    = port_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    ack_d     = 2'b00;
    err_d     = 2'b00;
    grant     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant   = (req0 && req1) ? ~last_q : req1;
          port_d  = grant;
          we_d    = grant ? we1    : we0;
          addr_d  = grant ? addr1  : addr0;
          wdata_d = grant ? wdata1 : wdata0;
          last_d  = grant;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_read  = in_range && !we_q;
        mem_write = in_range && we_q;
        if (in_range && !we_q) begin
          if (port_q) rdata1_d = mem_rdata;
          else        rdata0_d = mem_rdata;
        end
        ack_d[port_q] = 1'b1;
        err_d[port_q] = ~in_range;
        state_d       = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobes drop the moment reset is asserted so an abandoned write never lands.
    if (!rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_ff @(posedge clk) begin
    port_q  <= port_d;
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign ack0        = ack_q[0];
  assign ack1        = ack_q[1];
  assign err0        = err_q[0];
  assign err1        = err_q[1];
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign busy        = (state_q != IDLE);
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

endmodule
